// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall vectors,
// controller FSM state codes and the zero redirect word.
package pipe_ctrl_pkg;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DIV_START = 2'b01,
    ST_DIV_WAIT  = 2'b10,
    ST_DIV_DONE  = 2'b11
  } state_e;

  // A divide is in flight (and must be annulled on a flush) only while the
  // divider has been started but has not yet handed back a result.
  function automatic logic div_in_flight(input state_e s);
    return (s == ST_DIV_START) || (s == ST_DIV_WAIT);
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: arbitrates MEM exceptions, the shared
// iterative divider handshake (with watchdog) and ID load-use stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_div_req,
  input  logic        div_ready,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_timeout
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Next-state, watchdog and same-cycle control outputs; while rst is low
  // every output is held quiet regardless of the hazard inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stall     = STALL_NONE;
    flush     = 1'b0;
    new_pc    = ZERO_WORD;
    div_annul = 1'b0;
    if (!rst) begin
      state_d   = ST_IDLE;
      cnt_d     = CNT_ZERO;
      timeout_d = 1'b0;
    end else if (excp_req) begin
      flush     = 1'b1;
      new_pc    = excp_pc;
      div_annul = div_in_flight(state_q);
      state_d   = ST_IDLE;
      cnt_d     = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_div_req) begin
            stall   = STALL_EX;
            state_d = ST_DIV_START;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end else begin
            stall = STALL_NONE;
          end
        end
        ST_DIV_START: begin
          stall   = STALL_EX;
          cnt_d   = CNT_ZERO;
          state_d = ST_DIV_WAIT;
        end
        ST_DIV_WAIT: begin
          stall = STALL_EX;
          if (div_ready) begin
            state_d = ST_DIV_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Divider hung: abandon it and let EX advance with garbage.
            timeout_d = 1'b1;
            div_annul = 1'b1;
            state_d   = ST_DIV_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DIV_DONE: begin
          // ex_div_req still belongs to the finishing divide; do not restart.
          stall   = STALL_NONE;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Controller state, watchdog count and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign div_start   = (state_q == ST_DIV_START);
  assign div_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-age reference model queues the
// expected outputs per cycle and a negedge monitor compares them.
module tb_pipe_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        ex_div_req = 1'b0;
  logic        div_ready = 1'b0;
  logic        excp_req = 1'b0;
  logic [31:0] excp_pc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_start;
  logic        div_annul;
  logic        div_timeout;

  pipe_ctrl #(.DIV_TIMEOUT(TMO), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_div_req(ex_div_req),
    .div_ready(div_ready), .excp_req(excp_req), .excp_pc(excp_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .div_start(div_start),
    .div_annul(div_annul), .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        start;
    logic        annul;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: age = cycles since the divide was accepted
  // (-1 none, 0 start cycle, k>=1 k-th wait cycle); done = result hand-off cycle.
  int age = -1;
  bit done = 1'b0;
  bit m_tmo = 1'b0;

  function automatic exp_t actual();
    exp_t a;
    a.stall = stall; a.flush = flush; a.new_pc = new_pc;
    a.start = div_start; a.annul = div_annul; a.tmo = div_timeout;
    return a;
  endfunction

  task automatic model_step();
    exp_t e;
    e = '0;
    e.tmo   = m_tmo;
    e.start = (age == 0);
    if (excp_req) begin
      e.flush  = 1'b1;
      e.new_pc = excp_pc;
      e.annul  = (age >= 0);
      age = -1; done = 1'b0;
    end else if (done) begin
      done = 1'b0;
    end else if (age == 0) begin
      e.stall = 6'b001111;
      age = 1;
    end else if (age > 0) begin
      e.stall = 6'b001111;
      if (div_ready) begin
        done = 1'b1; age = -1;
      end else if (age == TMO) begin
        e.annul = 1'b1; m_tmo = 1'b1; done = 1'b1; age = -1;
      end else begin
        age = age + 1;
      end
    end else if (ex_div_req) begin
      e.stall = 6'b001111;
      age = 0;
    end else if (stallreq_id) begin
      e.stall = 6'b000111;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit id, input bit dreq, input bit rdy,
                       input bit ex, input logic [31:0] pc);
    stallreq_id = id; ex_div_req = dreq; div_ready = rdy;
    excp_req = ex; excp_pc = pc;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    exp_t a;
    a = actual();
    checks++;
    if (a !== exp_t'(0)) begin
      errors++;
      $display("FAIL %s: got stall=%b flush=%b new_pc=%h start=%b annul=%b tmo=%b, required all zero",
               name, a.stall, a.flush, a.new_pc, a.start, a.annul, a.tmo);
    end
  endtask

  // Monitor: the controller presents a response every cycle, compared mid-cycle.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs @%0t: got stall=%b flush=%b pc=%h start=%b annul=%b tmo=%b, required stall=%b flush=%b pc=%h start=%b annul=%b tmo=%b",
                   $time, a.stall, a.flush, a.new_pc, a.start, a.annul, a.tmo,
                   e.stall, e.flush, e.new_pc, e.start, e.annul, e.tmo);
        end
      end
    end
  end

  initial begin
    // Reset state, with hazard inputs active to show they are masked.
    stallreq_id = 1'b1; ex_div_req = 1'b1;
    #12;
    check_quiet("reset_initial");
    stallreq_id = 1'b0; ex_div_req = 1'b0;
    #4 rst = 1'b1;
    @(posedge clk); #1;

    drive(0, 0, 0, 0, 32'h0);
    // Load-use stall for one cycle.
    drive(1, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);

    // Divide: request at cycle 0, ready at cycle 8, done at 9 with req still high.
    for (int c = 0; c <= 7; c++) drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);

    // Exception while waiting on the divider.
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 1, 32'h0000_0020);
    drive(0, 0, 0, 0, 32'h0);

    // Simultaneous divide request and load-use; then ready together with exception.
    drive(1, 1, 0, 0, 32'h0);
    drive(1, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 1, 1, 32'hDEAD_BEE0);
    drive(0, 0, 0, 0, 32'h0);

    // Watchdog: ready never arrives.
    drive(0, 1, 0, 0, 32'h0);
    for (int c = 0; c < TMO + 1; c++) drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 32'h0);

    // Back-to-back divides separated by a single idle cycle.
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);

    // Randomized traffic, including stray ready pulses and exceptions.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, $urandom());
    end

    // Asynchronous reset in the middle of a divide wait.
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    stallreq_id = 1'b1; ex_div_req = 1'b1;
    #2 rst = 1'b0;
    #1 check_quiet("reset_mid_divide");
    @(posedge clk); #2;
    check_quiet("reset_held");
    stallreq_id = 1'b0; ex_div_req = 1'b0;
    age = -1; done = 1'b0; m_tmo = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Collects hazard requests from ID (load-use) and EX (multi-cycle divide).
- Collects exception requests from MEM.
- Drives the per-stage stall vector, the flush strobe and the redirect PC into the PC register and the if_id/id_ex/ex_mem/mem_wb pipeline registers.
- Sequences the shared iterative divider with a start/ready handshake and a watchdog.

Parameters:
DIV_TIMEOUT, 40, max DIV_WAIT cycles before the divide is abandoned; must be < 2**CNT_W and >= 1
CNT_W, 6, width of watchdog counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stallreq_id  in  1  load-use hazard detected in ID
ex_div_req  in  1  EX holds div/divu needing the divider; held high until EX advances
div_ready  in  1  divider result valid, 1-cycle pulse
excp_req  in  1  exception taken in MEM
excp_pc  in  32  exception handler address
stall  out  6  hold bits: [0] PC, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] WB
flush  out  1  clear all pipeline registers at next edge
new_pc  out  32  redirect target, valid when flush=1
div_start  out  1  1-cycle start pulse to the divider
div_annul  out  1  abort in-flight divide, 1-cycle pulse
div_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, div_timeout=0.
  - Therefore stall=0, flush=0, new_pc=0, div_start=0, div_annul=0.
  - Reset mid-divide abandons the divide silently; no annul pulse is issued.
- FSM states: IDLE, DIV_START, DIV_WAIT, DIV_DONE. These are registered.
- stall, flush, new_pc and div_annul are combinational from state and inputs, valid in the same cycle. div_start is a Moore output (state==DIV_START).
- Priority, highest first: excp_req, divide sequencing, stallreq_id.
- excp_req=1 in any state:
  - flush=1, new_pc=excp_pc, stall=6'b000000.
  - div_annul=1 if state is DIV_START or DIV_WAIT.
  - Next state=IDLE, cnt=0.
- With excp_req=0, flush=0 and new_pc=32'h0.
- IDLE:
  - ex_div_req=1: stall=6'b001111 (ex_mem receives a bubble); next DIV_START.
  - Else stallreq_id=1: stall=6'b000111 (id_ex receives a bubble); stay IDLE.
  - Else stall=0.
- DIV_START: div_start=1, stall=6'b001111, cnt<=0; next DIV_WAIT.
- DIV_WAIT: stall=6'b001111.
  - div_ready=1: next DIV_DONE.
  - Else if cnt==DIV_TIMEOUT-1: div_timeout<=1 (sticky until reset), div_annul=1 this cycle, next DIV_DONE.
  - Else cnt<=cnt+1.
- DIV_DONE: stall=6'b000000 so EX advances with the result. ex_div_req is ignored this cycle because it still reflects the same instruction. Next IDLE.
- A div_ready pulse outside DIV_WAIT is ignored.
- stallreq_id during a divide is subsumed by 001111.
- Back-to-back divides: a new ex_div_req seen in IDLE after DIV_DONE starts a fresh sequence. Minimum spacing is 1 IDLE cycle.

Decomposition:
- Shared defines include holds:
  - stall encodings STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111.
  - FSM state codes (2-bit).
  - ZERO_WORD=32'h0.
- Single module; the watchdog counter is inline. No sub-module is warranted.

Test Plan:
1. Reset: drive rst=0 asynchronously during DIV_WAIT -> all outputs 0 immediately. After release, state IDLE and div_timeout=0.
2. Load-use: stallreq_id=1 for one cycle in IDLE -> stall=6'b000111 that cycle, 6'b000000 the next; div_start stays 0.
3. Divide: ex_div_req rises at cycle 0, div_ready pulses at cycle 8 ->
   - stall=6'b001111 for cycles 0-8; div_start=1 only at cycle 1.
   - Cycle 9 (DIV_DONE): stall=0 with ex_div_req still 1, no restart.
   - Cycle 10: IDLE.
4. Exception mid-divide: excp_req=1 with excp_pc=32'h00000020 in DIV_WAIT -> same cycle flush=1, new_pc=32'h00000020, stall=0, div_annul=1. Next cycle IDLE, flush=0.
5. Watchdog: DIV_TIMEOUT=4, div_ready held 0 ->
   - 4th DIV_WAIT cycle: div_annul=1 and div_timeout set.
   - Next cycle DIV_DONE with stall=0.
   - div_timeout remains 1 until rst=0.
6. Simultaneous events:
   - ex_div_req=1 with stallreq_id=1 -> stall=6'b001111.
   - div_ready=1 with excp_req=1 in DIV_WAIT -> flush=1, div_annul=1, next IDLE, DIV_DONE skipped.
